stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 100, rate of tick pulses while counting; DIV = CLK_HZ/TICK_HZ, which SHALL be an integer >= 2.
REQ-003 SHALL have parameter DEB_CYCLES, default 500_000, consecutive stable cycles required to accept a button level.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 btn_ss  input  1  raw start/stop button, asynchronous, active-high.
REQ-007 btn_lr  input  1  raw lap/reset button, asynchronous, active-high.
REQ-008 tick  output  1  one-cycle enable pulse to the downstream counter chain.
REQ-009 clr  output  1  one-cycle synchronous clear pulse to the downstream counter chain.
REQ-010 lap_freeze  output  1  display hold; counters keep running.
REQ-011 state  output  2  current FSM state, encoded per the package.

Function
REQ-012 Each button SHALL pass a 2-FF synchronizer, then a debouncer, then rising-edge detection; debounced level updates only after DEB_CYCLES consecutive identical synchronized samples.
REQ-013 A press event SHALL be a one-cycle pulse, DEB_CYCLES+3 cycles after a clean raw rising edge; releases generate no event.
REQ-014 FSM states: IDLE, RUN, PAUSED, LAP.
REQ-015 IDLE: ss -> RUN; lr ignored.
REQ-016 RUN: ss -> PAUSED; lr -> LAP.
REQ-017 LAP: lr -> RUN; ss -> PAUSED.
REQ-018 PAUSED: ss -> RUN; lr -> IDLE.
REQ-019 Both press events in the same cycle: ss SHALL take effect and lr SHALL be discarded.
REQ-020 Prescaler: width $clog2(DIV), counts 0..DIV-1 only in RUN and LAP, wraps to 0, tick registered high for exactly the cycle after the prescaler reaches DIV-1.
REQ-021 The first tick SHALL occur DIV cycles after entry to RUN from IDLE.
REQ-022 In PAUSED the prescaler SHALL hold its value, so no sub-tick time is lost across a pause.
REQ-023 On entry to IDLE the prescaler SHALL clear to 0 and clr SHALL pulse for exactly one cycle.
REQ-024 tick and clr SHALL never be high in the same cycle; tick SHALL be 0 in IDLE and PAUSED.
REQ-025 lap_freeze SHALL be 1 exactly while in LAP, registered at the state change.

Reset
REQ-026 rst SHALL asynchronously force: state=IDLE, tick=0, clr=0, lap_freeze=0, prescaler=0, synchronizer, debounce counters and levels=0.
REQ-027 Reset mid-operation SHALL produce no clr pulse and no press event after release, even if a button is held through reset.

Configuration
REQ-028 Macro STOPWATCH_LAP_EN defined: LAP state and lap_freeze behave per REQ-016/017/025.
REQ-029 Macro absent: no LAP state, lr in RUN ignored, lap_freeze tied 0, lr acts only in PAUSED.

Structure
REQ-030 Package stopwatch_pkg SHALL hold the state enum typedef (2-bit) and the synchronizer-depth constant (2).
REQ-031 Sub-module btn_conditioner (synchronizer + debouncer + edge detect, parameter DEB_CYCLES) SHALL be instantiated once per button.

Verification (CLK_HZ=1000, TICK_HZ=100 -> DIV=10, DEB_CYCLES=4)
REQ-032 Clean btn_ss held 10 cycles -> state RUN 7 cycles after the raw edge; tick every 10 cycles, first tick 10 cycles after entering RUN.
REQ-033 btn_ss bouncing with 3-cycle highs and 3-cycle lows for 30 cycles, then low -> no press event, state stays IDLE.
REQ-034 RUN, ss event with prescaler=6 -> PAUSED, no ticks for 50 cycles; ss again -> RUN, next tick 4 cycles later.
REQ-035 PAUSED, lr event -> IDLE, clr high exactly 1 cycle, prescaler 0, tick 0.
REQ-036 LAP_EN defined: RUN, lr -> lap_freeze=1 with ticks continuing every 10 cycles; lr again -> lap_freeze=0; ss and lr events in the same cycle while in RUN -> PAUSED.
REQ-037 rst asserted mid-RUN with btn_ss held -> tick, clr and lap_freeze=0 and state=IDLE immediately; after release with btn_ss still held -> state remains IDLE.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - state encoding and synchronizer depth shared by the stopwatch controller
package stopwatch_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    LAP    = 2'd3
  } state_t;

endpackage

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - raw button to one-cycle press pulse: synchronizer, debouncer, rising-edge detect
module btn_conditioner
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic [CW-1:0]          cnt;
  logic                   level;
  logic                   valid;

  // valid stays low until the first level is accepted after reset, so a button
  // held through reset is adopted silently instead of reported as a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      prev  <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      valid <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], btn};
      press <= 1'b0;
      if (sync[SYNC_STAGES-1] != prev) begin
        prev <= sync[SYNC_STAGES-1];
        cnt  <= CW'(1);
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        cnt   <= CW'(DEB_CYCLES);
        level <= prev;
        valid <= 1'b1;
        press <= prev & ~level & valid;
      end else if (cnt != CW'(DEB_CYCLES)) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch control FSM with tick prescaler and clear/lap outputs
// Lap state and lap_freeze exist only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 100,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   btn_ss,
  input  logic   btn_lr,
  output logic   tick,
  output logic   clr,
  output logic   lap_freeze,
  output state_t state
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic          ss_ev;
  logic          lr_ev;
  state_t        state_nx;
  logic [PW-1:0] presc;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_ss (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_ss),
    .press (ss_ev)
  );

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_lr (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_lr),
    .press (lr_ev)
  );

  // ss is tested first everywhere, so a simultaneous lr is dropped
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (ss_ev) state_nx = RUN;
      RUN: begin
        if (ss_ev) state_nx = PAUSED;
`ifdef STOPWATCH_LAP_EN
        else if (lr_ev) state_nx = LAP;
`endif
      end
`ifdef STOPWATCH_LAP_EN
      LAP: begin
        if (ss_ev)      state_nx = PAUSED;
        else if (lr_ev) state_nx = RUN;
      end
`endif
      PAUSED: begin
        if (ss_ev)      state_nx = RUN;
        else if (lr_ev) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      presc <= '0;
      tick  <= 1'b0;
      clr   <= 1'b0;
    end else begin
      state <= state_nx;
      tick  <= 1'b0;
      clr   <= (state_nx == IDLE) && (state != IDLE);
      // PAUSED falls through both branches, holding the partial tick period
      if (state == RUN || state == LAP) begin
        if (presc == PW'(DIV - 1)) begin
          presc <= '0;
          tick  <= 1'b1;
        end else begin
          presc <= presc + PW'(1);
        end
      end else if (state == IDLE || state_nx == IDLE) begin
        presc <= '0;
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lap_freeze <= 1'b0;
    else     lap_freeze <= (state_nx == LAP);
  end
`else
  assign lap_freeze = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - stopwatch_ctrl bench: cycle model comparison plus directed literal checks
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DEB     = 4;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int MASK    = (1 << DEB) - 1;
  localparam int LOGN    = 8192;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_ON = 1'b1;
`else
  localparam bit LAP_ON = 1'b0;
`endif

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   btn_ss = 1'b0;
  logic   btn_lr = 1'b0;
  logic   tick, clr, lap_freeze;
  state_t state;

  stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .tick(tick), .clr(clr), .lap_freeze(lap_freeze), .state(state)
  );

  always #5 clk = ~clk;

  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  bit     checking = 1'b0;
  bit     tick_log [LOGN];
  bit     clr_log  [LOGN];
  bit     lap_log  [LOGN];
  state_t st_log   [LOGN];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: transitions as a rule table, ticks from elapsed running time
  state_t m_state = IDLE;
  bit     m_tick = 1'b0, m_clr = 1'b0, m_lap = 1'b0;
  int     m_elapsed = 0;
  bit     sy1 [2], sy2 [2], lvl [2], vld [2], prs [2];
  int     hist [2], hcnt [2];

  function automatic state_t next_of(state_t s, bit ss, bit lr);
    if (ss) return (s == RUN || s == LAP) ? PAUSED : RUN;
    if (lr) begin
      if (s == PAUSED)          return IDLE;
      if (s == RUN && LAP_ON)   return LAP;
      if (s == LAP)             return RUN;
    end
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = IDLE; m_tick = 0; m_clr = 0; m_lap = 0; m_elapsed = 0;
      for (int b = 0; b < 2; b++) begin
        sy1[b] = 0; sy2[b] = 0; lvl[b] = 0; vld[b] = 0; prs[b] = 0; hist[b] = 0; hcnt[b] = 0;
      end
    end else begin
      state_t n;
      n = next_of(m_state, prs[0], prs[1]);
      if (m_state == RUN || m_state == LAP) begin
        m_elapsed++;
        m_tick = (m_elapsed % DIV) == 0;
      end else begin
        m_tick = 0;
      end
      if (n == IDLE) m_elapsed = 0;
      m_clr   = (n == IDLE) && (m_state != IDLE);
      m_lap   = (n == LAP);
      m_state = n;
      for (int b = 0; b < 2; b++) begin
        bit s;
        s = sy2[b];
        sy2[b] = sy1[b];
        sy1[b] = (b == 0) ? btn_ss : btn_lr;
        hist[b] = ((hist[b] << 1) | int'(s)) & MASK;
        if (hcnt[b] < DEB) hcnt[b]++;
        prs[b] = 0;
        if (hcnt[b] == DEB && (hist[b] == MASK || hist[b] == 0)) begin
          if (s && !lvl[b] && vld[b]) prs[b] = 1;
          lvl[b] = s;
          vld[b] = 1;
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (checking) begin
      chk("tick", tick, m_tick);
      chk("clr", clr, m_clr);
      chk("lap_freeze", lap_freeze, m_lap);
      chk("state", state, m_state);
    end
    if (cyc < LOGN) begin
      tick_log[cyc] = tick; clr_log[cyc] = clr; lap_log[cyc] = lap_freeze; st_log[cyc] = state;
    end
  end

  task automatic hold(input bit ss, input bit lr, input int n);
    btn_ss = ss;
    btn_lr = lr;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic int ticks_in(int a, int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += int'(tick_log[i]);
    return n;
  endfunction

  function automatic int count_not_idle(int a, int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += (st_log[i] != IDLE) ? 1 : 0;
    return n;
  endfunction

  function automatic int clr_in(int a, int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += int'(clr_log[i]);
    return n;
  endfunction

  initial begin
    int c;
    int r;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_state", state, IDLE);
    chk("reset_tick", tick, 0);
    chk("reset_clr", clr, 0);
    chk("reset_lap", lap_freeze, 0);
    rst = 1'b0;
    checking = 1'b1;
    hold(0, 0, 10);

    c = cyc;
    repeat (5) begin hold(1, 0, 3); hold(0, 0, 3); end
    hold(0, 0, 20);
    chk("bounce_stays_idle", count_not_idle(c, cyc - 1), 0);

    c = cyc;
    hold(1, 0, 10);
    hold(0, 0, 30);
    chk("start_before", st_log[c + 6], IDLE);
    chk("start_run", st_log[c + 7], RUN);
    chk("first_tick_gap", ticks_in(c + 7, c + 16), 0);
    chk("first_tick", tick_log[c + 17], 1);
    chk("tick_period_gap", ticks_in(c + 18, c + 26), 0);
    chk("second_tick", tick_log[c + 27], 1);

    hold(0, 0, 7);
    c = cyc;
    hold(1, 0, 8);
    hold(0, 0, 50);
    chk("pause_prev", st_log[c + 6], RUN);
    chk("pause", st_log[c + 7], PAUSED);
    chk("pause_no_ticks", ticks_in(c + 7, c + 57), 0);

    c = cyc;
    hold(1, 0, 8);
    hold(0, 0, 12);
    chk("resume", st_log[c + 7], RUN);
    chk("resume_gap", ticks_in(c + 7, c + 9), 0);
    chk("resume_tick", tick_log[c + 10], 1);

    c = cyc;
    hold(1, 0, 8);
    hold(0, 0, 4);
    chk("pause2", st_log[c + 7], PAUSED);
    c = cyc;
    hold(1, 1, 8);
    hold(0, 0, 4);
    chk("both_in_paused", st_log[c + 7], RUN);
    chk("both_no_clr", clr_log[c + 7], 0);
    c = cyc;
    hold(1, 0, 8);
    hold(0, 0, 4);
    chk("pause3", st_log[c + 7], PAUSED);

    c = cyc;
    hold(0, 1, 8);
    hold(0, 0, 4);
    chk("to_idle", st_log[c + 7], IDLE);
    chk("clr_before", clr_log[c + 6], 0);
    chk("clr_pulse", clr_log[c + 7], 1);
    chk("clr_after", clr_log[c + 8], 0);
    chk("idle_no_tick", tick_log[c + 7], 0);

    c = cyc;
    hold(0, 1, 8);
    hold(0, 0, 4);
    chk("idle_lr_ignored", count_not_idle(c, cyc - 1), 0);

    c = cyc;
    hold(1, 0, 8);
    hold(0, 0, 14);
    chk("restart", st_log[c + 7], RUN);
    chk("restart_gap", ticks_in(c + 7, c + 16), 0);
    chk("restart_tick", tick_log[c + 17], 1);

    c = cyc;
    hold(0, 1, 8);
    hold(0, 0, 30);
    chk("lr_in_run", st_log[c + 7], LAP_ON ? LAP : RUN);
    chk("lap_freeze_on", lap_log[c + 7], int'(LAP_ON));
    chk("ticks_during_lap", ticks_in(c + 8, c + 37), 3);

    c = cyc;
    hold(0, 1, 8);
    hold(0, 0, 4);
    chk("lap_exit", st_log[c + 7], RUN);
    chk("lap_freeze_off", lap_log[c + 7], 0);

    c = cyc;
    hold(1, 1, 8);
    hold(0, 0, 4);
    chk("both_in_run", st_log[c + 7], PAUSED);
    hold(1, 0, 8);
    hold(0, 0, 10);

    hold(1, 0, 2);
    rst = 1'b1;
    #1;
    chk("midrst_state", state, IDLE);
    chk("midrst_tick", tick, 0);
    chk("midrst_clr", clr, 0);
    chk("midrst_lap", lap_freeze, 0);
    @(posedge clk);
    #2;
    hold(1, 0, 3);
    rst = 1'b0;
    c = cyc;
    hold(1, 0, 30);
    hold(0, 0, 5);
    chk("held_through_reset", count_not_idle(c, cyc - 1), 0);
    chk("no_clr_after_reset", clr_in(c, cyc - 1), 0);

    repeat (300) begin
      r = $urandom_range(0, 39);
      if (r == 0) begin
        rst = 1'b1;
        hold(1'($urandom_range(0, 1)), 1'b0, 2);
        rst = 1'b0;
      end
      hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), $urandom_range(1, 12));
    end
    hold(0, 0, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
